// File: rtl/frame_buf_arb_if.sv
// Frame-buffer arbiter bus: requester handshakes plus the
// single-port memory side, grouped for the arbiter port list.
interface frame_buf_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 29
);
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_req_addr;
  logic [DATA_WIDTH-1:0] wr_req_data;
  logic                  wr_ack;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  rd_done;
  logic                  rd_resp_valid;
  logic [DATA_WIDTH-1:0] rd_resp_data;
  logic                  rd_timeout;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_rd_en;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_rd_data_valid;

  modport slave (
    input  wr_req, wr_req_addr, wr_req_data,
    input  rd_req, rd_req_addr,
    input  mem_rd_data, mem_rd_data_valid,
    output wr_ack, rd_done, rd_resp_valid,
    output rd_resp_data, rd_timeout, busy,
    output mem_wr_addr, mem_wr_data, mem_wr_en,
    output mem_rd_addr, mem_rd_en
  );

  modport master (
    output wr_req, wr_req_addr, wr_req_data,
    output rd_req, rd_req_addr,
    output mem_rd_data, mem_rd_data_valid,
    input  wr_ack, rd_done, rd_resp_valid,
    input  rd_resp_data, rd_timeout, busy,
    input  mem_wr_addr, mem_wr_data, mem_wr_en,
    input  mem_rd_addr, mem_rd_en
  );
endinterface

// File: rtl/frame_buf_arb.sv
// Frame-buffer arbiter: one memory access at a time between a
// pixel writer and a display reader, fair on ties.
module frame_buf_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 29,
  parameter int WR_HOLD    = 2,
  parameter int RD_TIMEOUT = 8
) (
  input logic            clk,
  input logic            reset,
  frame_buf_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_t;

  localparam int CW = 8;
  localparam logic [CW-1:0] WR_LAST = CW'(WR_HOLD - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_TIMEOUT - 1);

  state_t                r_state, w_state_nx;
  logic                  r_last_wr, w_last_wr_nx;
  logic [CW-1:0]         r_cnt, w_cnt_nx, w_cnt_inc;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nx;
  logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_nx;
  logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_nx;
  logic [DATA_WIDTH-1:0] r_rd_data, w_rd_data_nx;
  logic                  r_wr_en, w_wr_en_nx;
  logic                  r_rd_en, w_rd_en_nx;
  logic                  r_wr_ack, w_wr_ack_nx;
  logic                  r_rd_done, w_rd_done_nx;
  logic                  r_rd_vld, w_rd_vld_nx;
  logic                  r_rd_to, w_rd_to_nx;
  logic                  w_gnt_wr, w_gnt_rd;

  // r_last_wr=1 means the writer won last, so the reader wins a tie
  assign w_gnt_wr = bus.wr_req & (~bus.rd_req | ~r_last_wr);
  assign w_gnt_rd = bus.rd_req & (~bus.wr_req | r_last_wr);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 8'd1;

  always_comb begin
    w_state_nx   = r_state;
    w_last_wr_nx = r_last_wr;
    w_cnt_nx     = r_cnt;
    w_wr_addr_nx = r_wr_addr;
    w_wr_data_nx = r_wr_data;
    w_rd_addr_nx = r_rd_addr;
    w_rd_data_nx = r_rd_data;
    w_rd_to_nx   = r_rd_to;
    w_wr_en_nx   = 1'b1;
    w_rd_en_nx   = 1'b1;
    w_wr_ack_nx  = 1'b0;
    w_rd_done_nx = 1'b0;
    w_rd_vld_nx  = 1'b0;
    unique case (r_state)
      IDLE: begin
        unique case (1'b1)
          w_gnt_wr: begin
            w_state_nx   = WRITE;
            w_last_wr_nx = 1'b1;
            w_cnt_nx     = '0;
            w_wr_addr_nx = bus.wr_req_addr;
            w_wr_data_nx = bus.wr_req_data;
            w_wr_en_nx   = 1'b0;
            w_wr_ack_nx  = (WR_LAST == '0);
          end
          w_gnt_rd: begin
            w_state_nx   = READ;
            w_last_wr_nx = 1'b0;
            w_cnt_nx     = '0;
            w_rd_addr_nx = bus.rd_req_addr;
            w_rd_en_nx   = 1'b0;
          end
          default: ;
        endcase
      end
      WRITE: begin
        if (r_cnt == WR_LAST) begin
          w_state_nx = IDLE;
        end else begin
          w_cnt_nx    = w_cnt_inc;
          w_wr_en_nx  = 1'b0;
          w_wr_ack_nx = (w_cnt_inc == WR_LAST);
        end
      end
      READ: begin
        if (bus.mem_rd_data_valid) begin
          w_state_nx   = IDLE;
          w_rd_data_nx = bus.mem_rd_data;
          w_rd_vld_nx  = 1'b1;
          w_rd_done_nx = 1'b1;
        end else if (r_cnt == RD_LAST) begin
          w_state_nx   = IDLE;
          w_rd_done_nx = 1'b1;
          w_rd_to_nx   = 1'b1;
        end else begin
          w_cnt_nx   = w_cnt_inc;
          w_rd_en_nx = 1'b0;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_last_wr <= 1'b0;
      r_cnt     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_wr_en   <= 1'b1;
      r_rd_en   <= 1'b1;
      r_wr_ack  <= 1'b0;
      r_rd_done <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_to   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_last_wr <= w_last_wr_nx;
      r_cnt     <= w_cnt_nx;
      r_wr_addr <= w_wr_addr_nx;
      r_wr_data <= w_wr_data_nx;
      r_rd_addr <= w_rd_addr_nx;
      r_rd_data <= w_rd_data_nx;
      r_wr_en   <= w_wr_en_nx;
      r_rd_en   <= w_rd_en_nx;
      r_wr_ack  <= w_wr_ack_nx;
      r_rd_done <= w_rd_done_nx;
      r_rd_vld  <= w_rd_vld_nx;
      r_rd_to   <= w_rd_to_nx;
    end
  end

  assign bus.wr_ack        = r_wr_ack;
  assign bus.rd_done       = r_rd_done;
  assign bus.rd_resp_valid = r_rd_vld;
  assign bus.rd_resp_data  = r_rd_data;
  assign bus.rd_timeout    = r_rd_to;
  assign bus.busy          = (r_state != IDLE);
  assign bus.mem_wr_addr   = r_wr_addr;
  assign bus.mem_wr_data   = r_wr_data;
  assign bus.mem_wr_en     = r_wr_en;
  assign bus.mem_rd_addr   = r_rd_addr;
  assign bus.mem_rd_en     = r_rd_en;

endmodule

// File: tb/tb_frame_buf_arb.sv
// Scoreboard bench for frame_buf_arb with a latency-programmable
// memory model on the read port.
module tb_frame_buf_arb;
  localparam int DW = 32;
  localparam int AW = 29;
  localparam int WH = 2;
  localparam int RT = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frame_buf_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  frame_buf_arb #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .WR_HOLD(WH), .RD_TIMEOUT(RT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            ok;
    int            run;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int lat = 2;
  bit stray = 0;
  bit exp_to = 0;
  bit gap_on = 0;
  logic [DW-1:0] last_rd = '0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  int rlow = 0;
  int wrun = 0;
  int rrun = 0;
  int rlast = 0;
  int gap = 0;
  bit seen_acc = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // memory model: answers a read on its (lat+1)-th enabled cycle
  initial begin
    bus.mem_rd_data_valid = 1'b0;
    bus.mem_rd_data = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_wr_en === 1'b0)
        mem[bus.mem_wr_addr] = bus.mem_wr_data;
      if (bus.mem_rd_en === 1'b0) begin
        rlow++;
        if (lat >= 0 && rlow == lat + 1) begin
          bus.mem_rd_data_valid = 1'b1;
          bus.mem_rd_data = mem.exists(bus.mem_rd_addr) ?
                            mem[bus.mem_rd_addr] : 32'h5A5A5A5A;
        end else begin
          bus.mem_rd_data_valid = 1'b0;
          bus.mem_rd_data = '0;
        end
      end else begin
        rlow = 0;
        bus.mem_rd_data_valid = stray;
        bus.mem_rd_data = stray ? 32'hDEADBEEF : '0;
      end
    end
  end

  // monitor: pops the scoreboard on every ack / done
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.mem_wr_en === 1'b0) wrun++;
      else wrun = 0;
      if (bus.mem_rd_en === 1'b0) rrun++;
      else begin
        if (rrun != 0) rlast = rrun;
        rrun = 0;
      end
      chk("no_overlap", 64'(bus.mem_wr_en | bus.mem_rd_en), 1);
      chk("vld_wo_done",
          64'(bus.rd_resp_valid & ~bus.rd_done), 0);
      if (!gap_on) begin
        seen_acc = 0;
        gap = 0;
      end else if (bus.mem_wr_en && bus.mem_rd_en) begin
        gap++;
      end else begin
        if (seen_acc && gap > 0) chk("idle_gap", 64'(gap), 1);
        seen_acc = 1;
        gap = 0;
      end
      if (bus.wr_ack === 1'b1) begin
        if (sb.size() == 0) chk("wr_unexp", 1, 0);
        else begin
          e = sb.pop_front();
          chk("wr_kind", 64'(e.is_wr), 1);
          chk("wr_addr", 64'(bus.mem_wr_addr), 64'(e.addr));
          chk("wr_data", 64'(bus.mem_wr_data), 64'(e.data));
          chk("wr_hold", 64'(wrun), 64'(e.run));
          chk("wr_nodone", 64'(bus.rd_done), 0);
        end
      end
      if (bus.rd_done === 1'b1) begin
        if (sb.size() == 0) chk("rd_unexp", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rd_kind", 64'(e.is_wr), 0);
          chk("rd_valid", 64'(bus.rd_resp_valid), 64'(e.ok));
          if (e.ok) last_rd = e.data;
          else exp_to = 1;
          chk("rd_data", 64'(bus.rd_resp_data), 64'(last_rd));
          chk("rd_run", 64'(rlast), 64'(e.run));
          chk("rd_en_hi", 64'(bus.mem_rd_en), 1);
          chk("rd_addr", 64'(bus.mem_rd_addr), 64'(e.addr));
          chk("rd_to", 64'(bus.rd_timeout), 64'(exp_to));
        end
      end
    end
  end

  task automatic chk_rst();
    chk("rst_wr_en", 64'(bus.mem_wr_en), 1);
    chk("rst_rd_en", 64'(bus.mem_rd_en), 1);
    chk("rst_wr_addr", 64'(bus.mem_wr_addr), 0);
    chk("rst_rd_addr", 64'(bus.mem_rd_addr), 0);
    chk("rst_wr_data", 64'(bus.mem_wr_data), 0);
    chk("rst_rd_data", 64'(bus.rd_resp_data), 0);
    chk("rst_ack", 64'(bus.wr_ack), 0);
    chk("rst_done", 64'(bus.rd_done), 0);
    chk("rst_vld", 64'(bus.rd_resp_valid), 0);
    chk("rst_to", 64'(bus.rd_timeout), 0);
    chk("rst_busy", 64'(bus.busy), 0);
  endtask

  task automatic do_write(input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    int k;
    bus.wr_req = 1'b1;
    bus.wr_req_addr = a;
    bus.wr_req_data = d;
    sb.push_back('{1'b1, a, d, 1'b1, WH});
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.wr_ack === 1'b1) break;
    end
    if (k == 30) chk("wr_wait", 0, 1);
    bus.wr_req = 1'b0;
    @(negedge clk);
    chk("wr_idle", 64'(bus.busy), 0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input bit ok,
                         input logic [DW-1:0] d, input int run);
    int k;
    bus.rd_req = 1'b1;
    bus.rd_req_addr = a;
    sb.push_back('{1'b0, a, d, ok, run});
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.rd_done === 1'b1) break;
    end
    if (k == 40) chk("rd_wait", 0, 1);
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("rd_idle", 64'(bus.busy), 0);
  endtask

  initial begin
    int nw;
    int nr;
    int k;
    bus.wr_req = 1'b0;
    bus.wr_req_addr = '0;
    bus.wr_req_data = '0;
    bus.rd_req = 1'b0;
    bus.rd_req_addr = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst();
    reset = 1'b1;
    @(negedge clk);

    do_write(29'h10, 32'hA5A5A5A5);
    lat = 2;
    do_read(29'h10, 1'b1, 32'hA5A5A5A5, 3);

    stray = 1;
    repeat (3) @(negedge clk);
    do_write(29'h20, 32'h12345678);
    repeat (2) @(negedge clk);
    stray = 0;
    @(negedge clk);
    chk("stray_keep", 64'(bus.rd_resp_data), 64'hA5A5A5A5);
    chk("stray_to", 64'(bus.rd_timeout), 0);

    lat = -1;
    do_read(29'h30, 1'b0, 32'h0, RT);
    lat = 2;
    do_write(29'h40, 32'hCAFEF00D);
    chk("to_sticky", 64'(bus.rd_timeout), 1);
    do_read(29'h40, 1'b1, 32'hCAFEF00D, 3);
    chk("to_sticky2", 64'(bus.rd_timeout), 1);

    bus.wr_req = 1'b1;
    bus.wr_req_addr = 29'h50;
    bus.wr_req_data = 32'h55555555;
    @(negedge clk);
    chk("mw_en_lo", 64'(bus.mem_wr_en), 0);
    reset = 1'b0;
    bus.wr_req = 1'b0;
    exp_to = 0;
    last_rd = '0;
    @(negedge clk);
    chk_rst();

    sb.push_back('{1'b1, 29'h100, 32'h11111111, 1'b1, WH});
    sb.push_back('{1'b0, 29'h100, 32'h11111111, 1'b1, 3});
    sb.push_back('{1'b1, 29'h104, 32'h22222222, 1'b1, WH});
    sb.push_back('{1'b0, 29'h104, 32'h22222222, 1'b1, 3});
    bus.wr_req_addr = 29'h100;
    bus.wr_req_data = 32'h11111111;
    bus.rd_req_addr = 29'h100;
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    gap_on = 1;
    reset = 1'b1;
    @(negedge clk);
    chk("first_grant_wr", 64'(bus.mem_wr_en), 0);
    nw = 0;
    nr = 0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.wr_ack === 1'b1) begin
        nw++;
        bus.wr_req_addr = 29'h104;
        bus.wr_req_data = 32'h22222222;
        if (nw == 2) bus.wr_req = 1'b0;
      end
      if (bus.rd_done === 1'b1) begin
        nr++;
        bus.rd_req_addr = 29'h104;
        if (nr == 2) bus.rd_req = 1'b0;
      end
      if (nw == 2 && nr == 2) break;
    end
    if (k == 100) chk("cont_wait", 0, 1);
    @(negedge clk);
    gap_on = 0;
    chk("sb_empty", 64'(sb.size()), 0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_buf_arb.md
FRAME_BUF_ARB -- requirements
Module: frame_buf_arb

Interface
REQ-001 The block SHALL have the following parameters, one per line:
- DATA_WIDTH, 32, width of the pixel data word.
- ADDR_WIDTH, 29, width of the memory word address.
- WR_HOLD, 2, number of cycles mem_wr_en is held asserted per write (range 1..15).
- RD_TIMEOUT, 8, number of READ-state cycles allowed before a read aborts (range 1..255).

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous reset, active-low.
- wr_req  in  1  active-high write request from the pixel producer.
- wr_req_addr  in  ADDR_WIDTH  write address.
- wr_req_data  in  DATA_WIDTH  write data.
- wr_ack  out  1  one-cycle pulse: write completed.
- rd_req  in  1  active-high read request from the display side.
- rd_req_addr  in  ADDR_WIDTH  read address.
- rd_done  out  1  one-cycle pulse: read finished (success or abort).
- rd_resp_valid  out  1  one-cycle pulse, coincident with rd_done, on success only.
- rd_resp_data  out  DATA_WIDTH  read data; valid when rd_resp_valid is high.
- rd_timeout  out  1  sticky error flag: a read aborted.
- busy  out  1  high whenever the FSM is not IDLE.
- mem_wr_addr  out  ADDR_WIDTH  memory write address.
- mem_wr_data  out  DATA_WIDTH  memory write data.
- mem_wr_en  out  1  memory write enable, active-low.
- mem_rd_addr  out  ADDR_WIDTH  memory read address.
- mem_rd_en  out  1  memory read enable, active-low.
- mem_rd_data  in  DATA_WIDTH  memory read data.
- mem_rd_data_valid  in  1  active-high: mem_rd_data is valid this cycle.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, WRITE and READ. Only one memory access SHALL be in flight at a time.
REQ-004 In IDLE, the arbiter SHALL grant as follows:
- only wr_req high -> WRITE.
- only rd_req high -> READ.
- both high -> the requester not granted last, tracked by a last_grant bit.
- neither high -> remain in IDLE.
REQ-005 At the grant edge, the addresses and write data SHALL be latched into mem_wr_addr/mem_wr_data or mem_rd_addr. Requester inputs are don't-care after the grant.
REQ-006 WRITE SHALL drive mem_wr_en low for exactly WR_HOLD consecutive cycles. wr_ack SHALL pulse on the last of those cycles, and the FSM SHALL then return to IDLE.
REQ-007 READ SHALL drive mem_rd_en low and count cycles from 0.
- On the first cycle in which mem_rd_data_valid is high: capture mem_rd_data into rd_resp_data, pulse rd_resp_valid and rd_done on the next cycle, deassert mem_rd_en, and return to IDLE.
REQ-008 If RD_TIMEOUT cycles elapse in READ without mem_rd_data_valid, the block SHALL:
- pulse rd_done with rd_resp_valid low;
- set rd_timeout;
- leave rd_resp_data unchanged;
- return to IDLE.
REQ-009 A requester SHALL hold its req until it sees its ack/done. A req still high in the ack/done cycle is a new request.
REQ-010 mem_wr_en and mem_rd_en SHALL never be low in the same cycle, and both SHALL be high in IDLE.
REQ-011 mem_rd_data_valid SHALL be ignored outside READ.
REQ-012 The READ cycle counter SHALL saturate, never wrap, and SHALL clear on READ entry.
REQ-013 rd_timeout SHALL clear only on reset.
REQ-014 A back-to-back grant SHALL cost one IDLE cycle between accesses.

Reset
REQ-015 While reset is low at a rising edge, the block SHALL drive the following values:
- FSM = IDLE; last_grant = read, so write wins the first tie.
- mem_wr_en = mem_rd_en = 1.
- mem_wr_addr, mem_rd_addr, mem_wr_data, rd_resp_data = 0.
- wr_ack, rd_done, rd_resp_valid, rd_timeout, busy = 0.
REQ-016 Reset asserted mid-access SHALL abort the access with no ack/done pulse, and outputs SHALL match REQ-015 on the following cycle.

Verification
REQ-017 Single write: wr_req=1, addr=0x10, data=0xA5A5A5A5 at cycle 0. Expect mem_wr_en low cycles 1-2 with addr 0x10 and data 0xA5A5A5A5, wr_ack at cycle 2, IDLE at cycle 3.
REQ-018 Single read: rd_req=1, addr=0x10 at cycle 0; model returns valid=1, data=0xA5A5A5A5 at cycle 3. Expect rd_resp_valid=rd_done=1, rd_resp_data=0xA5A5A5A5 at cycle 4, and mem_rd_en high at cycle 4.
REQ-019 Contention: wr_req and rd_req both held high from reset release. Expect grants W, R, W, R alternating, one IDLE cycle between accesses, and enables never overlapping.
REQ-020 Timeout: rd_req=1, model never asserts valid. Expect mem_rd_en low for 8 cycles, then rd_done=1, rd_resp_valid=0, rd_timeout=1 staying high; a subsequent write still completes.
REQ-021 Reset mid-write: reset low at cycle 1 of WRITE. Expect no wr_ack, mem_wr_en=1 and all REQ-015 values the next cycle, and write granted first after release.
REQ-022 Stray valid: mem_rd_data_valid=1 in IDLE and WRITE. Expect no rd_done, no rd_resp_valid, and rd_resp_data unchanged.
